// File: rtl/moore_seq_detect.sv
// =============================================================================
// Module   : moore_seq_detect
// Brief    : Parametrised Moore serial pattern detector with KMP-style fallback.
//            Optional saturating match counter enabled by MOORE_SEQ_DETECT_CNT_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module moore_seq_detect #(
  parameter int          N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          SW      = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  input  logic          x_en,
  output logic          z,
  output logic [SW-1:0] s
`ifdef MOORE_SEQ_DETECT_CNT_EN
  ,
  output logic [7:0]    match_cnt
`endif
);

  localparam int          c_NUM_CODES = 2**SW;
  localparam logic [SW-1:0] c_FULL    = SW'(N);

  // Successor of state k after accepting bit b. The history of state k is
  // exactly the k-bit pattern prefix, so the fallback is a pure constant.
  function automatic logic [SW-1:0] f_next(input int k, input logic b);
    logic [16:0]   hist;
    logic [SW-1:0] res;
    logic          found;
    logic          ok;
    int            lim;
    res   = '0;
    found = 1'b0;
    hist  = '0;
    lim   = 0;
    if (k > N) begin
      res = '0;
    end else if ((k == N) && !OVERLAP) begin
      res = (b == PATTERN[N-1]) ? SW'(1) : '0;
    end else begin
      hist[0] = b;
      for (int i = 1; i <= k; i++) begin
        hist[i] = PATTERN[N-k+i-1];
      end
      lim = (k + 1 > N) ? N : k + 1;
      for (int j = lim; j >= 1; j--) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (hist[i] != PATTERN[N-j+i]) ok = 1'b0;
        end
        if (ok && !found) begin
          res   = SW'(j);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  logic [SW-1:0] w_nxt0 [c_NUM_CODES];
  logic [SW-1:0] w_nxt1 [c_NUM_CODES];

  generate
    for (genvar k = 0; k < c_NUM_CODES; k++) begin : g_tab
      localparam logic [SW-1:0] c_N0 = f_next(k, 1'b0);
      localparam logic [SW-1:0] c_N1 = f_next(k, 1'b1);
      assign w_nxt0[k] = c_N0;
      assign w_nxt1[k] = c_N1;
    end
  endgenerate

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (x_en) begin
      state_d = x ? w_nxt1[state_q] : w_nxt0[state_q];
    end
  end

  always_comb begin
    z = (state_q == c_FULL);
    s = state_q;
  end

`ifdef MOORE_SEQ_DETECT_CNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (x_en && (state_d == c_FULL) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
